spi_loader: RTL and testbench

SPI_LOADER -- requirements
Module: spi_loader

---
 rtl/spi_loader.sv | 151 +++++++++++++++
 tb/tb_spi_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_loader.sv
// spi_loader: SPI slave that receives 32-bit words (mode 0, MSB first) and writes them over AHB-Lite.
//   clk, reset                 system clock, synchronous active-high reset
//   spi_sck/spi_cs_n/spi_mosi  asynchronous SPI slave pins
//   spi_hready, spi_hrest      AHB transfer done / error response; spi_hrdata is ignored
//   spi_haddr/hwdata/hwrite/htrans/hsize/hburst/hprot/hmastlock  AHB-Lite master outputs
//   busy, err, overrun         transfer in flight / sticky bus error / sticky dropped word
//   word_count                 data words committed since reset
module spi_loader #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [3:0]  HPROT_VAL   = 4'b0011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    input  logic        spi_hready,
    input  logic        spi_hrest,
    input  logic [31:0] spi_hrdata,
    output logic [31:0] spi_haddr,
    output logic [31:0] spi_hwdata,
    output logic        spi_hwrite,
    output logic        spi_hmastlock,
    output logic [2:0]  spi_hsize,
    output logic [2:0]  spi_hburst,
    output logic [1:0]  spi_htrans,
    output logic [3:0]  spi_hprot,
    output logic        busy,
    output logic        err,
    output logic        overrun,
    output logic [15:0] word_count
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic        sck_prev_q;
    logic [4:0]  bit_cnt_q;
    logic [30:0] shift_q;
    logic        hdr_q;
    state_t      state_q;
    logic        pending_q;
    logic [31:0] hold_q, addr_q, haddr_q, hwdata_q;
    logic [1:0]  htrans_q;
    logic        hwrite_q, err_q, overrun_q;
    logic [15:0] word_count_q;
    logic        sck_s, cs_s, mosi_s, sck_rise, word_done, pending_clr;
    logic [31:0] word_d;
    logic        unused_hrdata;

    assign unused_hrdata = ^spi_hrdata;
    assign sck_s       = sck_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise    = sck_s & ~sck_prev_q;
    assign word_done   = ~cs_s & sck_rise & (bit_cnt_q == 5'd31);
    assign word_d      = {shift_q, mosi_s};
    // the holding register frees up on the same edge its word moves to hwdata
    assign pending_clr = (state_q == ADDR) & spi_hready;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_q  <= sck_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cs_s) begin
            bit_cnt_q <= '0;
            hdr_q     <= 1'b0;
            shift_q   <= '0;
        end else if (sck_rise) begin
            shift_q   <= {shift_q[29:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31)
                hdr_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            hold_q       <= '0;
            addr_q       <= '0;
            haddr_q      <= '0;
            hwdata_q     <= '0;
            htrans_q     <= 2'b00;
            hwrite_q     <= 1'b0;
            err_q        <= 1'b0;
            overrun_q    <= 1'b0;
            word_count_q <= '0;
        end else begin
            if (pending_clr)
                pending_q <= 1'b0;
            if (word_done && hdr_q) begin
                if (pending_q && !pending_clr)
                    overrun_q <= 1'b1;
                else begin
                    hold_q    <= word_d;
                    pending_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: if (pending_q) begin
                    state_q  <= ADDR;
                    htrans_q <= 2'b10;
                    hwrite_q <= 1'b1;
                    haddr_q  <= addr_q;
                end
                ADDR: if (spi_hready) begin
                    state_q  <= DATA;
                    htrans_q <= 2'b00;
                    hwrite_q <= 1'b0;
                    hwdata_q <= hold_q;
                end
                DATA: if (spi_hready) begin
                    state_q      <= IDLE;
                    word_count_q <= word_count_q + 16'd1;
                    addr_q       <= addr_q + 32'd4;
                    if (spi_hrest)
                        err_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            // a new frame's start address overrides any concurrent increment
            if (word_done && !hdr_q)
                addr_q <= {word_d[31:2], 2'b00};
        end
    end

    assign spi_haddr     = haddr_q;
    assign spi_hwdata    = hwdata_q;
    assign spi_htrans    = htrans_q;
    assign spi_hwrite    = hwrite_q;
    assign spi_hmastlock = 1'b0;
    assign spi_hsize     = 3'b010;
    assign spi_hburst    = 3'b000;
    assign spi_hprot     = HPROT_VAL;
    assign busy          = (state_q != IDLE) | pending_q;
    assign err           = err_q;
    assign overrun       = overrun_q;
    assign word_count    = word_count_q;
endmodule

// File: tb/tb_spi_loader.sv
// tb_spi_loader: table-driven and scoreboard bench for spi_loader.
module tb_spi_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic        hready = 1'b1, hrest = 1'b0;
    logic [31:0] hrdata = 32'h0;
    logic [31:0] haddr, hwdata;
    logic        hwrite, hmastlock, busy, err, overrun;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;
    logic [3:0]  hprot;
    logic [15:0] word_count;

    spi_loader dut (
        .clk(clk), .reset(reset), .spi_sck(sck), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .spi_hready(hready), .spi_hrest(hrest), .spi_hrdata(hrdata),
        .spi_haddr(haddr), .spi_hwdata(hwdata), .spi_hwrite(hwrite), .spi_hmastlock(hmastlock),
        .spi_hsize(hsize), .spi_hburst(hburst), .spi_htrans(htrans), .spi_hprot(hprot),
        .busy(busy), .err(err), .overrun(overrun), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic [31:0] data;} xfer_t;
    typedef struct {logic [31:0] hdr; logic [31:0] data; logic [31:0] exp_addr;} vec_t;

    xfer_t       exp_q[$];
    xfer_t       mon_e;
    vec_t        vecs[4];
    logic [31:0] cap;
    logic        dph = 1'b0;
    int          n_checks = 0, n_fail = 0, exp_wc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        xfer_t x;
        x.addr = a;
        x.data = d;
        exp_q.push_back(x);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        tick(3);
        sck = 1'b1;
        tick(3);
        sck = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic begin_frame(input logic [31:0] a);
        cs_n = 1'b0;
        tick(4);
        send_word(a);
    endtask

    task automatic end_frame;
        tick(4);
        cs_n = 1'b1;
        tick(6);
    endtask

    task automatic wait_idle;
        int k = 0;
        while ((busy || dph) && k < 300) begin
            tick(1);
            k++;
        end
        if (k >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy %b after %0d cycles, required 0", busy, k);
        end
    endtask

    task automatic wait_addr;
        int k = 0;
        while (htrans != 2'b10 && k < 300) begin
            tick(1);
            k++;
        end
        if (k >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL addr_timeout: htrans %b after %0d cycles, required 10", htrans, k);
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (reset)
                    dph = 1'b0;
                else if (dph && hready) begin
                    dph = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: addr %h data %h, required no write", cap, hwdata);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("wr_addr", cap, mon_e.addr);
                        check("wr_data", hwdata, mon_e.data);
                    end
                end else if (htrans == 2'b10 && hready) begin
                    cap = haddr;
                    check("hwrite", 32'(hwrite), 32'd1);
                    dph = 1'b1;
                end
            end
        join_none

        vecs[0] = '{hdr: 32'h0000_0100, data: 32'hDEAD_BEEF, exp_addr: 32'h0000_0100};
        vecs[1] = '{hdr: 32'h0000_1237, data: 32'h0000_0000, exp_addr: 32'h0000_1234};
        vecs[2] = '{hdr: 32'h8000_0001, data: 32'hFFFF_FFFF, exp_addr: 32'h8000_0000};
        vecs[3] = '{hdr: 32'h0000_0004, data: 32'hA5A5_5A5A, exp_addr: 32'h0000_0004};

        tick(3);
        check("rst_htrans", 32'(htrans), 32'd0);
        check("rst_hwrite", 32'(hwrite), 32'd0);
        check("rst_haddr", haddr, 32'd0);
        check("rst_hwdata", hwdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_wc", 32'(word_count), 32'd0);
        check("hsize", 32'(hsize), 32'd2);
        check("hburst", 32'(hburst), 32'd0);
        check("hprot", 32'(hprot), 32'd3);
        check("hmastlock", 32'(hmastlock), 32'd0);
        reset = 1'b0;
        tick(2);

        for (int i = 0; i < 4; i++) begin
            begin_frame(vecs[i].hdr);
            push_exp(vecs[i].exp_addr, vecs[i].data);
            send_word(vecs[i].data);
            end_frame();
            wait_idle();
            exp_wc++;
            check("vec_wc", 32'(word_count), 32'(exp_wc));
            check("vec_sb_empty", 32'(exp_q.size()), 32'd0);
        end

        begin_frame(32'h0000_0203);
        push_exp(32'h200, 32'h0101_0101);
        push_exp(32'h204, 32'h0202_0202);
        push_exp(32'h208, 32'h0303_0303);
        send_word(32'h0101_0101);
        send_word(32'h0202_0202);
        send_word(32'h0303_0303);
        end_frame();
        wait_idle();
        exp_wc += 3;
        check("multi_wc", 32'(word_count), 32'(exp_wc));

        begin_frame(32'h0000_0400);
        push_exp(32'h400, 32'h1357_9BDF);
        for (int i = 31; i >= 1; i--) send_bit(1'(32'h1357_9BDF >> i));
        mosi = 1'b1;
        tick(3);
        sck = 1'b1;
        tick(3);
        check("lat_early", 32'(htrans), 32'd0);
        tick(1);
        check("lat_addr", 32'(htrans), 32'd2);
        tick(2);
        sck = 1'b0;
        end_frame();
        wait_idle();
        exp_wc++;

        hready = 1'b0;
        begin_frame(32'h0000_0500);
        push_exp(32'h500, 32'hCAFE_F00D);
        send_word(32'hCAFE_F00D);
        wait_addr();
        for (int j = 0; j < 5; j++) begin
            check("stall_htrans", 32'(htrans), 32'd2);
            check("stall_haddr", haddr, 32'h500);
            tick(1);
        end
        hready = 1'b1;
        check("stall_htrans6", 32'(htrans), 32'd2);
        end_frame();
        wait_idle();
        exp_wc++;
        check("stall_wc", 32'(word_count), 32'(exp_wc));

        hrest = 1'b1;
        begin_frame(32'h0000_0600);
        push_exp(32'h600, 32'h1111_1111);
        push_exp(32'h604, 32'h2222_2222);
        send_word(32'h1111_1111);
        tick(10);
        check("err_set", 32'(err), 32'd1);
        hrest = 1'b0;
        send_word(32'h2222_2222);
        end_frame();
        wait_idle();
        exp_wc += 2;
        check("err_sticky", 32'(err), 32'd1);
        check("err_wc", 32'(word_count), 32'(exp_wc));

        check("ovr_clear", 32'(overrun), 32'd0);
        hready = 1'b0;
        begin_frame(32'h0000_0700);
        push_exp(32'h700, 32'hAAAA_0001);
        send_word(32'hAAAA_0001);
        send_word(32'hBBBB_0002);
        tick(4);
        check("ovr_set", 32'(overrun), 32'd1);
        hready = 1'b1;
        end_frame();
        wait_idle();
        exp_wc++;
        check("ovr_wc", 32'(word_count), 32'(exp_wc));

        cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < 20; i++) send_bit(1'(i & 1));
        end_frame();
        wait_idle();
        check("partial_wc", 32'(word_count), 32'(exp_wc));

        begin_frame(32'hFFFF_FFFC);
        push_exp(32'hFFFF_FFFC, 32'h7777_0000);
        push_exp(32'h0000_0000, 32'h8888_0000);
        send_word(32'h7777_0000);
        send_word(32'h8888_0000);
        end_frame();
        wait_idle();
        exp_wc += 2;
        check("wrap_wc", 32'(word_count), 32'(exp_wc));
        check("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        hready = 1'b0;
        begin_frame(32'h0000_0800);
        send_word(32'h0000_0055);
        wait_addr();
        reset = 1'b1;
        tick(1);
        check("rst_mid_htrans", 32'(htrans), 32'd0);
        reset = 1'b0;
        hready = 1'b1;
        cs_n = 1'b1;
        tick(10);
        exp_wc = 0;
        check("rst_mid_wc", 32'(word_count), 32'(exp_wc));
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_err", 32'(err), 32'd0);
        check("rst_mid_ovr", 32'(overrun), 32'd0);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
